// File: rtl/data_bus_xbar.sv
// data_bus_xbar: registered NUM_SRC -> NUM_DST crossbar with a double-buffered (shadow/active) route table.
// Optional feature macro: DATA_BUS_XBAR_PIPE_EN adds a second output register stage (latency 2).
module data_bus_xbar #(
    parameter int  WIDTH   = 8,
    parameter int  NUM_SRC = 11,
    parameter int  NUM_DST = 11,
    localparam int SEL_W   = $clog2(NUM_SRC + 1),
    localparam int DST_W   = (NUM_DST > 1) ? $clog2(NUM_DST) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic                     cfg_we,
    input  logic [DST_W-1:0]         cfg_dst,
    input  logic [SEL_W-1:0]         cfg_sel,
    input  logic                     commit,
    input  logic [NUM_DST-1:0]       dst_hold,
    input  logic                     err_clr,
    output logic [NUM_DST*WIDTH-1:0] dst_data,
    output logic [NUM_DST-1:0]       dst_valid,
    output logic                     route_pending,
    output logic                     sel_err
);

    logic               cfg_bad;
    logic [NUM_DST-1:0] diff_vec;
    logic [NUM_DST-1:0] bad_vec;
    logic               route_pending_reg;
    logic               sel_err_reg;
    logic               sel_err_next;

    // Out-of-range destination index: the write is dropped and flagged.
    assign cfg_bad = cfg_we && (int'(cfg_dst) >= NUM_DST);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DST; gi++) begin : g_dst
            logic [SEL_W-1:0] shadow_reg;
            logic [SEL_W-1:0] shadow_next;
            logic [SEL_W-1:0] active_reg;
            logic [SEL_W-1:0] active_next;
            logic [WIDTH-1:0] route_data;
            logic             route_valid;
            logic [WIDTH-1:0] out_data_reg;
            logic             out_valid_reg;

            // Commit copies the post-write shadow, so a same-cycle write goes straight through.
            always_comb begin
                shadow_next = shadow_reg;
                if (cfg_we && !cfg_bad && (cfg_dst == DST_W'(gi))) begin
                    shadow_next = cfg_sel;
                end
                active_next = commit ? shadow_next : active_reg;
            end

            assign diff_vec[gi] = (shadow_next != active_next);
            assign bad_vec[gi]  = (int'(active_reg) > NUM_SRC);

            always_comb begin
                route_data  = '0;
                route_valid = (active_reg == '0);
                for (int k = 0; k < NUM_SRC; k++) begin
                    if (active_reg == SEL_W'(k + 1)) begin
                        route_data  = src_data[k*WIDTH +: WIDTH];
                        route_valid = src_valid[k];
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    shadow_reg <= shadow_next;
                    active_reg <= active_next;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    out_data_reg  <= '0;
                    out_valid_reg <= 1'b0;
                end else if (!dst_hold[gi]) begin
                    out_data_reg  <= route_data;
                    out_valid_reg <= route_valid;
                end
            end

`ifdef DATA_BUS_XBAR_PIPE_EN
            logic [WIDTH-1:0] pipe_data_reg;
            logic             pipe_valid_reg;

            // Hold freezes both stages together so release neither drops nor repeats a word.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pipe_data_reg  <= '0;
                    pipe_valid_reg <= 1'b0;
                end else if (!dst_hold[gi]) begin
                    pipe_data_reg  <= out_data_reg;
                    pipe_valid_reg <= out_valid_reg;
                end
            end

            assign dst_data[gi*WIDTH +: WIDTH] = pipe_data_reg;
            assign dst_valid[gi]               = pipe_valid_reg;
`else
            assign dst_data[gi*WIDTH +: WIDTH] = out_data_reg;
            assign dst_valid[gi]               = out_valid_reg;
`endif
        end
    endgenerate

    // A new error in the same cycle as err_clr keeps the flag set.
    assign sel_err_next = cfg_bad || (|bad_vec) || (sel_err_reg && !err_clr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            route_pending_reg <= 1'b0;
            sel_err_reg       <= 1'b0;
        end else begin
            route_pending_reg <= |diff_vec;
            sel_err_reg       <= sel_err_next;
        end
    end

    assign route_pending = route_pending_reg;
    assign sel_err       = sel_err_reg;

endmodule
